// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - 16x16 minefield generator; MINE_SAFE_ZONE_EN widens the start-cell exclusion to its 3x3 block
module mine_placer #(
  parameter int          NUM_MINES = 40,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mine_start,
  input  logic [7:0] start_cell_addr,
  output logic       mine_done,
  output logic       busy,
  output logic       cell_we,
  output logic [7:0] cell_addr,
  output logic [4:0] cell_data
);

  typedef enum logic [1:0] {IDLE, PLACE, COUNT, DONE} state_t;

  state_t       state, next_state;
  logic         start_q;
  logic [15:0]  lfsr;
  logic [15:0]  lfsr_next;
  logic [255:0] bitmap;
  logic [7:0]   placed;
  logic [7:0]   scan;
  logic [7:0]   start_cell;
  logic [7:0]   cand;
  logic         start_edge;
  logic         in_zone;
  logic         accept;
  logic         placed_done;
  logic [3:0]   nbr_count;
  logic signed [4:0] nr, nc;

  logic       mine_done_d, busy_d, cell_we_d;
  logic [7:0] cell_addr_d;
  logic [4:0] cell_data_d;

  assign start_edge = mine_start & ~start_q;
  assign cand       = lfsr[7:0];
  assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

`ifdef MINE_SAFE_ZONE_EN
  logic signed [4:0] d_row, d_col;
  always_comb begin
    d_row   = $signed({1'b0, cand[7:4]}) - $signed({1'b0, start_cell[7:4]});
    d_col   = $signed({1'b0, cand[3:0]}) - $signed({1'b0, start_cell[3:0]});
    in_zone = (d_row >= -5'sd1) && (d_row <= 5'sd1) &&
              (d_col >= -5'sd1) && (d_col <= 5'sd1);
  end
`else
  assign in_zone = (cand == start_cell);
`endif

  assign accept      = (state == PLACE) && !bitmap[cand] && !in_zone;
  assign placed_done = accept && ((placed + 8'd1) == 8'(NUM_MINES));

  // Row+1 on row 15 wraps to -16 in 5-bit signed, so the >=0 test rejects it too.
  always_comb begin
    nbr_count = 4'd0;
    nr        = 5'sd0;
    nc        = 5'sd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr = $signed({1'b0, scan[7:4]}) + 5'(dr);
        nc = $signed({1'b0, scan[3:0]}) + 5'(dc);
        if (!(dr == 0 && dc == 0) && (nr >= 5'sd0) && (nc >= 5'sd0))
          nbr_count = nbr_count + 4'(bitmap[{nr[3:0], nc[3:0]}]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start_edge) next_state = PLACE;
      PLACE: begin
        if (!mine_start)      next_state = IDLE;
        else if (placed_done) next_state = COUNT;
      end
      COUNT: begin
        if (!mine_start)          next_state = IDLE;
        else if (scan == 8'hFF)   next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mine_done_d = (state == DONE);
    busy_d      = (next_state != IDLE);
    cell_we_d   = (state == COUNT) && mine_start;
    cell_addr_d = 8'd0;
    cell_data_d = 5'd0;
    if (cell_we_d) begin
      cell_addr_d = scan;
      cell_data_d = {bitmap[scan], nbr_count};
    end
  end

  // The LFSR free-runs across rounds so placement depends on player timing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q    <= 1'b0;
      lfsr       <= SEED;
      bitmap     <= '0;
      placed     <= 8'd0;
      scan       <= 8'd0;
      start_cell <= 8'd0;
    end else begin
      start_q <= mine_start;
      lfsr    <= lfsr_next;
      if (state == IDLE && start_edge) begin
        start_cell <= start_cell_addr;
        bitmap     <= '0;
        placed     <= 8'd0;
        scan       <= 8'd0;
      end else if (accept) begin
        bitmap[cand] <= 1'b1;
        placed       <= placed + 8'd1;
      end else if (state == COUNT) begin
        scan <= scan + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mine_done <= 1'b0;
      busy      <= 1'b0;
      cell_we   <= 1'b0;
      cell_addr <= 8'd0;
      cell_data <= 5'd0;
    end else begin
      mine_done <= mine_done_d;
      busy      <= busy_d;
      cell_we   <= cell_we_d;
      cell_addr <= cell_addr_d;
      cell_data <= cell_data_d;
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// tb/tb_mine_placer.sv - self-checking bench for mine_placer (honours MINE_SAFE_ZONE_EN if defined)
module tb_mine_placer;

  localparam int NM = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       mine_start;
  logic [7:0] start_cell_addr;
  logic       mine_done, busy, cell_we;
  logic [7:0] cell_addr;
  logic [4:0] cell_data;

  int checks = 0;
  int failures = 0;

  logic       flag[256];
  logic [3:0] cnt[256];
  logic       saved_flag[256];

  typedef struct {
    logic [7:0] start;
    int         gap;
    int         exp_writes;
    int         exp_mines;
    int         exp_dones;
  } vec_t;
  vec_t vecs[6];

  mine_placer #(.NUM_MINES(NM), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .mine_start(mine_start), .start_cell_addr(start_cell_addr),
    .mine_done(mine_done), .busy(busy), .cell_we(cell_we),
    .cell_addr(cell_addr), .cell_data(cell_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mine_done"}, int'(mine_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cell_we"}, int'(cell_we), 0);
    chk({tag, "_cell_addr"}, int'(cell_addr), 0);
    chk({tag, "_cell_data"}, int'(cell_data), 0);
  endtask

  function automatic int model_nbr(input int i);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int r = i / 16 + dr;
        int c = i % 16 + dc;
        if ((dr != 0 || dc != 0) && r >= 0 && r <= 15 && c >= 0 && c <= 15)
          s += int'(flag[r * 16 + c]);
      end
    return s;
  endfunction

  task automatic do_round(input logic [7:0] start, input int gap, input int abort_at,
                          output int writes, output int dones, output int order_err,
                          output int busy_at_done);
    for (int i = 0; i < 256; i++) begin flag[i] = 1'b0; cnt[i] = 4'd0; end
    writes = 0; dones = 0; order_err = 0; busy_at_done = -1;
    mine_start = 1'b0;
    repeat (gap) @(negedge clk);
    start_cell_addr = start;
    mine_start = 1'b1;
    for (int cyc = 0; cyc < 4000 && dones == 0; cyc++) begin
      @(negedge clk);
      if (cell_we) begin
        if (cell_addr != 8'(writes) || writes > 255) order_err++;
        flag[cell_addr] = cell_data[4];
        cnt[cell_addr]  = cell_data[3:0];
        writes++;
      end
      if (mine_done) begin
        dones++;
        busy_at_done = int'(busy);
      end
      if (abort_at >= 0 && writes == abort_at) break;
    end
  endtask

  task automatic eval_round(input string tag, input logic [7:0] start, input int exp_writes,
                            input int exp_mines, input int exp_dones, input int writes,
                            input int dones, input int order_err, input int busy_at_done);
    int mines = 0;
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      mines += int'(flag[i]);
      if (int'(cnt[i]) != model_nbr(i)) begin
        if (bad == 0)
          $display("FAIL %s_nbr cell=%02h actual=%0d expected=%0d", tag, i, cnt[i], model_nbr(i));
        bad++;
      end
    end
    chk({tag, "_writes"}, writes, exp_writes);
    chk({tag, "_order"}, order_err, 0);
    chk({tag, "_dones"}, dones, exp_dones);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    chk({tag, "_mines"}, mines, exp_mines);
    chk({tag, "_start_clear"}, int'(flag[start]), 0);
    chk({tag, "_nbr_bad"}, bad, 0);
`ifdef MINE_SAFE_ZONE_EN
    bad = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int r = int'(start[7:4]) + dr;
        int c = int'(start[3:0]) + dc;
        if (r >= 0 && r <= 15 && c >= 0 && c <= 15) bad += int'(flag[r * 16 + c]);
      end
    chk({tag, "_zone_clear"}, bad, 0);
    chk({tag, "_start_count"}, int'(cnt[start]), 0);
`endif
  endtask

  initial begin
    int w, d, o, bd, n_we, n_done, n_busy, diff;

    vecs[0] = '{8'h77, 2, 256, NM, 1};
    vecs[1] = '{8'h00, 3, 256, NM, 1};
    vecs[2] = '{8'hFF, 5, 256, NM, 1};
    vecs[3] = '{8'h0F, 7, 256, NM, 1};
    vecs[4] = '{8'hF0, 11, 256, NM, 1};
    vecs[5] = '{8'h38, 4, 256, NM, 1};

    rst = 1'b0; mine_start = 1'b0; start_cell_addr = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    do_round(8'h77, 3, -1, w, d, o, bd);
    eval_round("first", 8'h77, 256, NM, 1, w, d, o, bd);
    for (int i = 0; i < 256; i++) saved_flag[i] = flag[i];

    n_we = 0; n_done = 0; n_busy = 0;
    repeat (500) begin
      @(negedge clk);
      n_we += int'(cell_we); n_done += int'(mine_done); n_busy += int'(busy);
    end
    chk("hold_cell_we", n_we, 0);
    chk("hold_done", n_done, 0);
    chk("hold_busy", n_busy, 0);

    for (int v = 0; v < 6; v++) begin
      do_round(vecs[v].start, vecs[v].gap, -1, w, d, o, bd);
      eval_round($sformatf("vec%0d", v), vecs[v].start, vecs[v].exp_writes,
                 vecs[v].exp_mines, vecs[v].exp_dones, w, d, o, bd);
    end

    do_round(8'h77, 2, 100, w, d, o, bd);
    chk("abort_writes", w, 100);
    chk("abort_busy_before", int'(busy), 1);
    mine_start = 1'b0;
    @(negedge clk);
    chk("abort_cell_we", int'(cell_we), 0);
    chk("abort_busy", int'(busy), 0);
    n_we = 0; n_done = 0;
    repeat (20) begin
      @(negedge clk);
      n_we += int'(cell_we); n_done += int'(mine_done);
    end
    chk("abort_no_we", n_we, 0);
    chk("abort_no_done", n_done + d, 0);
    do_round(8'h33, 2, -1, w, d, o, bd);
    eval_round("after_abort", 8'h33, 256, NM, 1, w, d, o, bd);

    rst = 1'b0; mine_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    start_cell_addr = 8'h77;
    mine_start = 1'b1;
    repeat (5) @(negedge clk);
    chk("place_busy", int'(busy), 1);
    rst = 1'b0;
    mine_start = 1'b0;
    @(negedge clk);
    check_zero("reset_place");
    rst = 1'b1;
    do_round(8'h77, 3, -1, w, d, o, bd);
    eval_round("replay", 8'h77, 256, NM, 1, w, d, o, bd);
    diff = 0;
    for (int i = 0; i < 256; i++) if (flag[i] != saved_flag[i]) diff++;
    chk("replay_same_field", diff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
